// File: rtl/main_mem_block_responder.sv
// main_mem_block_responder: latency-modelled block memory serving cache refills and writebacks
module main_mem_block_responder #(
  parameter int BLOCK_WORDS  = 8,
  parameter int DEPTH_BLOCKS = 256,
  parameter int READ_LAT     = 10,
  parameter int WRITE_LAT    = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [31:0]               req_addr,
  input  logic [32*BLOCK_WORDS-1:0] req_wdata,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [32*BLOCK_WORDS-1:0] resp_rdata,
  output logic                      resp_write,
  output logic                      busy
);
  localparam int OFF  = $clog2(BLOCK_WORDS);
  localparam int IW   = $clog2(DEPTH_BLOCKS);
  localparam int BW   = 32*BLOCK_WORDS;
  localparam int MAXL = READ_LAT > WRITE_LAT ? READ_LAT : WRITE_LAT;
  localparam int CW   = $clog2(MAXL+1);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, next;
  logic [CW-1:0] cnt;
  logic wr_q;
  logic [BW-1:0] wdata_q;
  logic [IW-1:0] idx;
  logic [BW-1:0] mem [DEPTH_BLOCKS];
  logic accept, done, handshake, addr_unused;
  assign addr_unused = ^req_addr;
  assign req_ready = state == IDLE;
  assign busy = state != IDLE;
  always_comb begin
    accept = state == IDLE && req_valid;
    done = state == WAIT && cnt == '0;
    handshake = state == RESP && resp_ready;
    next = accept ? WAIT : done ? RESP : handshake ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      resp_valid <= 1'b0;
      resp_write <= 1'b0;
      resp_rdata <= '0;
      cnt <= '0;
      wr_q <= 1'b0;
    end else begin
      state <= next;
      if (accept) begin
        wr_q <= req_write;
        wdata_q <= req_wdata;
        idx <= req_addr[OFF +: IW];
        cnt <= req_write ? CW'(WRITE_LAT-1) : CW'(READ_LAT-1);
      end else if (state == WAIT)
        cnt <= cnt - 1'b1;
      if (done) begin
        resp_rdata <= wr_q ? wdata_q : mem[idx];
        resp_write <= wr_q;
        resp_valid <= 1'b1;
      end else if (handshake)
        resp_valid <= 1'b0;
    end
  end
  // the array is never reset; a reset while in WAIT simply never reaches the commit
  always_ff @(posedge clk) begin
    if (!reset && done && wr_q) mem[idx] <= wdata_q;
  end
endmodule

// File: tb/tb_main_mem_block_responder.sv
// tb_main_mem_block_responder: randomized scenarios checked against an array-based memory model
module tb_main_mem_block_responder;
  localparam int READ_LAT = 10;
  localparam int WRITE_LAT = 10;
  localparam int DEPTH = 256;
  logic clk = 0, reset = 1, req_valid = 0, req_write = 0, resp_ready = 0;
  logic [31:0] req_addr = 0;
  logic [255:0] req_wdata = 0;
  logic req_ready, resp_valid, resp_write, busy;
  logic [255:0] resp_rdata;
  int total = 0, bad = 0, cyc = 0;
  logic [255:0] ref_mem [DEPTH];
  bit known [DEPTH];

  main_mem_block_responder dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_write(resp_write), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int blk(input logic [31:0] a);
    return int'(a[3 +: 8]);
  endfunction

  function automatic logic [255:0] rnd_block();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic model(input logic w, input logic [31:0] a, input logic [255:0] d, output logic [255:0] e);
    if (w) begin
      ref_mem[blk(a)] = d;
      known[blk(a)] = 1;
    end
    e = ref_mem[blk(a)];
  endtask

  task automatic xact(input logic w, input logic [31:0] a, input logic [255:0] d, input int hold,
                      output logic [255:0] rd, output logic rw, output int lat,
                      output bit ready_bad, output bit unstable, output bit post_bad);
    int n, t;
    @(negedge clk);
    req_write = w; req_addr = a; req_wdata = d; req_valid = 1;
    t = 0;
    while (!req_ready && t < 50) begin @(negedge clk); t++; end
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    n = 1;
    ready_bad = req_ready;
    while (!resp_valid && n < 100) begin
      @(negedge clk);
      n++;
      ready_bad |= req_ready;
    end
    lat = n - 1;
    rd = resp_rdata; rw = resp_write; unstable = 0;
    for (int i = 0; i < hold; i++) begin
      req_valid = (i == 1); req_write = 1; req_addr = 32'h100; req_wdata = '1;
      @(negedge clk);
      if (resp_valid !== 1'b1 || resp_rdata !== rd || resp_write !== rw) unstable = 1;
    end
    req_valid = 0;
    resp_ready = 1;
    @(negedge clk);
    resp_ready = 0;
    post_bad = busy !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1;
  endtask

  task automatic test_reset();
    total++;
    if (busy !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ctrl got busy=%b valid=%b ready=%b exp 0 0 1", busy, resp_valid, req_ready);
    end
    total++;
    if (resp_write !== 1'b0 || resp_rdata !== '0) begin
      bad++; $display("FAIL reset_data got write=%b rdata=%h exp 0 and zero", resp_write, resp_rdata);
    end
  endtask

  task automatic test_write_read_alias();
    logic [255:0] d, e, rd; logic rw; int lat; bit rb, us, pb;
    for (int i = 0; i < 8; i++) d[32*i +: 32] = 32'hDEADBEEF ^ i;
    model(1, 32'h40, d, e);
    xact(1, 32'h40, d, 0, rd, rw, lat, rb, us, pb);
    total++;
    if (rd !== e || rw !== 1'b1) begin
      bad++; $display("FAIL wr_echo got %h w=%b exp %h w=1", rd, rw, e);
    end
    model(0, 32'h47, '0, e);
    xact(0, 32'h47, '0, 0, rd, rw, lat, rb, us, pb);
    total++;
    if (rd !== e || rw !== 1'b0) begin
      bad++; $display("FAIL rd_alias got %h w=%b exp %h w=0", rd, rw, e);
    end
  endtask

  task automatic test_latency();
    logic [255:0] e, rd; logic rw; int lat; bit rb, us, pb;
    model(0, 32'h40, '0, e);
    xact(0, 32'h40, '0, 0, rd, rw, lat, rb, us, pb);
    total++;
    if (lat !== READ_LAT) begin
      bad++; $display("FAIL rd_latency got %0d exp %0d", lat, READ_LAT);
    end
    total++;
    if (rb) begin
      bad++; $display("FAIL ready_in_wait got 1 exp 0");
    end
    total++;
    if (pb) begin
      bad++; $display("FAIL post_handshake got busy/valid/ready=%b%b%b exp 001", busy, resp_valid, req_ready);
    end
  endtask

  task automatic test_hold();
    logic [255:0] e, rd; logic rw; int lat; bit rb, us, pb;
    model(0, 32'h47, '0, e);
    xact(0, 32'h47, '0, 5, rd, rw, lat, rb, us, pb);
    total++;
    if (us) begin
      bad++; $display("FAIL hold_stable got unstable=1 exp 0");
    end
    total++;
    if (pb || rd !== e) begin
      bad++; $display("FAIL hold_done got %h post_bad=%b exp %h", rd, pb, e);
    end
  endtask

  task automatic test_wrap();
    logic [255:0] d, e, rd; logic rw; int lat; bit rb, us, pb;
    d = rnd_block();
    model(1, DEPTH*8 + 8, d, e);
    xact(1, DEPTH*8 + 8, d, 0, rd, rw, lat, rb, us, pb);
    model(0, 32'd8, '0, e);
    xact(0, 32'd8, '0, 0, rd, rw, lat, rb, us, pb);
    total++;
    if (rd !== e) begin
      bad++; $display("FAIL wrap_alias got %h exp %h", rd, e);
    end
  endtask

  task automatic test_reset_mid_write();
    logic [255:0] old_d, e, rd; logic rw; int lat; bit rb, us, pb;
    old_d = rnd_block();
    model(1, 32'd40, old_d, e);
    xact(1, 32'd40, old_d, 0, rd, rw, lat, rb, us, pb);
    @(negedge clk);
    req_write = 1; req_addr = 32'd40; req_wdata = ~old_d; req_valid = 1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    repeat (4) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    total++;
    if (busy !== 1'b0 || resp_valid !== 1'b0) begin
      bad++; $display("FAIL reset_mid got busy=%b valid=%b exp 0 0", busy, resp_valid);
    end
    model(0, 32'd40, '0, e);
    xact(0, 32'd40, '0, 0, rd, rw, lat, rb, us, pb);
    total++;
    if (rd !== e) begin
      bad++; $display("FAIL reset_drop got %h exp %h", rd, e);
    end
  endtask

  task automatic test_random();
    logic [255:0] d, e, rd; logic rw, w; logic [31:0] a; int lat, b, h; bit rb, us, pb;
    for (int k = 0; k < 12; k++) begin
      b = $urandom_range(8, 15);
      w = !known[b] || $urandom_range(0, 1) == 1;
      a = ($urandom_range(0, 3) << 11) | (b << 3) | $urandom_range(0, 7);
      d = rnd_block();
      h = $urandom_range(0, 3);
      model(w, a, d, e);
      xact(w, a, d, h, rd, rw, lat, rb, us, pb);
      total++;
      if (rd !== e || rw !== w) begin
        bad++; $display("FAIL rand_data[%0d] got %h w=%b exp %h w=%b", k, rd, rw, e, w);
      end
      total++;
      if (lat !== (w ? WRITE_LAT : READ_LAT) || rb || us || pb) begin
        bad++; $display("FAIL rand_timing[%0d] got lat=%0d flags=%b%b%b exp lat=%0d flags=000", k, lat, rb, us, pb, w ? WRITE_LAT : READ_LAT);
      end
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 10;
    int acc = 0, rsp = 0, guard = 0, b;
    int acc_cyc[$], acc_lat[$];
    logic [255:0] exp_q[$];
    logic exp_w[$];
    logic [255:0] e, ed;
    logic ew;
    bit adv = 1;
    resp_ready = 1;
    while ((acc < N || rsp < acc) && guard < 2000) begin
      @(negedge clk);
      guard++;
      if (resp_valid) begin
        rsp++;
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL b2b_extra got response %0d exp none", rsp);
        end else begin
          ed = exp_q.pop_front(); ew = exp_w.pop_front();
          if (resp_rdata !== ed || resp_write !== ew) begin
            bad++; $display("FAIL b2b_data got %h w=%b exp %h w=%b", resp_rdata, resp_write, ed, ew);
          end
        end
      end
      if (acc < N) begin
        if (adv) begin
          b = $urandom_range(0, 7);
          req_write = !known[b] || $urandom_range(0, 1) == 1;
          req_addr = ($urandom_range(0, 3) << 11) | (b << 3) | $urandom_range(0, 7);
          req_wdata = rnd_block();
          req_valid = 1;
          adv = 0;
        end
        if (req_ready) begin
          model(req_write, req_addr, req_wdata, e);
          exp_q.push_back(e); exp_w.push_back(req_write);
          acc_cyc.push_back(cyc); acc_lat.push_back(req_write ? WRITE_LAT : READ_LAT);
          acc++;
          adv = 1;
        end
      end else req_valid = 0;
    end
    req_valid = 0;
    resp_ready = 0;
    total++;
    if (guard >= 2000 || rsp !== N) begin
      bad++; $display("FAIL b2b_count got %0d responses exp %0d", rsp, N);
    end
    for (int i = 1; i < acc_cyc.size(); i++) begin
      total++;
      if (acc_cyc[i] - acc_cyc[i-1] !== acc_lat[i-1] + 2) begin
        bad++; $display("FAIL b2b_spacing[%0d] got %0d exp %0d", i, acc_cyc[i] - acc_cyc[i-1], acc_lat[i-1] + 2);
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 0;
    test_reset();
    test_write_read_alias();
    test_latency();
    test_hold();
    test_wrap();
    test_reset_mid_write();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
